out_channel_stream: RTL
=======================

# out_channel_stream

Downstream stage of the program executor: captures each word the executor writes to its output channel into a FIFO and streams the words off-chip over a valid/ready interface. When the executor signals program completion, the block drains the remaining words, flags the final one, and raises `done`. Sits between the executor's out-channel write port and the board-level result collector.

## Interface
- `DATA_WIDTH`, 12, width of one output word; matches the executor memory element width.
- `DEPTH`, 16, FIFO depth in words; power of two, ≥2.
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  executor writes one word to the output channel this cycle.
- `wr_data`  in  DATA_WIDTH  word written.
- `prog_finished`  in  1  executor has finished; level, sampled each cycle.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_data`  out  DATA_WIDTH  head-of-FIFO word.
- `out_last`  out  1  the current word is the final word of the program.
- `count`  out  $clog2(DEPTH)+1  words currently held.
- `overflow`  out  1  sticky; a word was dropped.
- `done`  out  1  all words delivered after finish.

## Operation
- States: RUN, DRAIN, DONE. Reset → RUN.
- RUN
  - Push on `wr_en`.
  - Pop when `out_valid && out_ready`.
  - `prog_finished` sampled high → DRAIN at the next edge. A `wr_en` in that same cycle is still accepted.
- DRAIN
  - `wr_en` ignored; the word is dropped and `overflow` is set.
  - Pops continue.
  - When a pop empties the FIFO, or on entry with `count==0` → DONE at the next edge.
- DONE
  - `done=1`, `out_valid=0`.
  - Writes dropped and set `overflow`.
  - Held until reset. `prog_finished` falling has no effect.
- Push/pop rules:
  - `out_valid = (count!=0) && state!=DONE`.
  - `out_data = mem[rd_ptr]` (head, show-ahead).
  - Push when full with no simultaneous pop: word dropped, `overflow` set, FIFO unchanged.
  - Push when full with a simultaneous pop: both occur, `count` stays at DEPTH.
  - Push and pop on an empty FIFO: pop is impossible (`out_valid=0`), so only the push occurs.
- `out_last = out_valid && state==DRAIN && count==1`.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is incremented or decremented by at most 1 per cycle.
- `overflow` is cleared only by reset.

## Timing
- Reset values:
  - `out_valid=0`, `out_last=0`, `out_data=0`.
  - `count=0`, `overflow=0`, `done=0`.
  - Pointers 0; memory contents don't-care.
- Write latency: a word written with `wr_en` at edge N appears at the head with `out_valid=1` in the cycle after edge N, provided the FIFO was empty.
- Read: the handshake completes at the edge where `out_valid && out_ready`. The next word, if any, appears immediately after that edge. Sustained throughput is 1 word/cycle.
- `out_data` is stable while `out_valid && !out_ready`.
- `done` rises one edge after the final pop, or one edge after entering DRAIN when the FIFO is empty.
- Reset asserted mid-stream or mid-drain discards all words and returns to RUN at that edge. Reset has priority over push and pop.

## Structure
- Shared package `fpga_pkg`:
  - `MemoryElementWidth` constant (12), the default for `DATA_WIDTH`.
  - `out_state_t` enum {RUN, DRAIN, DONE}.
- Sub-module `out_fifo_mem`: DEPTH×DATA_WIDTH register array with a synchronous write port and an asynchronous read port. Pointer, count and FSM logic stay in the top module.
- Expected size: about 150–250 lines of RTL.

## Test plan
- Single word: after reset, write 2 with `out_ready=1`, then assert `prog_finished`.
  - Expect `out_data=2`, `out_valid` one cycle after the write, and `out_last=1` on that word once in DRAIN.
  - Expect `done=1` one edge after the pop; `overflow=0`.
- Back-pressure: write 1,2,3 on consecutive cycles with `out_ready=0` for 5 cycles, then set it to 1.
  - Expect `count` to reach 3 and `out_data` to hold 1 while stalled.
  - Expect 1,2,3 delivered on consecutive cycles.
- Full and overflow: with `out_ready=0`, write 0..16 (17 words) into DEPTH=16.
  - Expect `count=16` and `overflow=1`.
  - Expect drained values 0..15 in order; word 16 is lost.
- Full with simultaneous push and pop: fill to 16, then drive `wr_en` and `out_ready` together for 4 cycles.
  - Expect `count` to stay 16, no overflow, and order preserved across pointer wrap.
- Empty finish: assert `prog_finished` with no writes.
  - Expect DRAIN then DONE, `done=1` two edges later, and `out_valid` never high.
- Late write and reset: write after `done=1` and expect `overflow=1`. Then pulse reset mid-stream with 5 words held.
  - Expect all outputs at their reset values at the next edge, and `count=0`.

Source files
------------

// File: rtl/fpga_pkg.sv
// Shared definitions for the executor's downstream stages.
package fpga_pkg;

    localparam int MemoryElementWidth = 12;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } out_state_t;

endpackage

// File: rtl/out_fifo_mem.sv
// FIFO storage: register array, synchronous write, asynchronous (show-ahead) read.
module out_fifo_mem #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset on storage; contents are only observed behind a valid count.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/out_channel_stream.sv
// Buffers executor out-channel writes and streams them over valid/ready,
// draining and flagging the last word once the program has finished.
module out_channel_stream
    import fpga_pkg::*;
#(
    parameter int DATA_WIDTH = MemoryElementWidth,
    parameter int DEPTH      = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       prog_finished,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]            state, state_nxt;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic [DATA_WIDTH-1:0] head;
    logic                  full, empty, pop, push, drop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign out_valid = !empty && (state != ST_DONE);
    assign pop       = out_valid && out_ready;
    // A pop frees the slot in the same edge, so a full FIFO can still take a word.
    assign push      = wr_en && (state == ST_RUN) && (!full || pop);
    assign drop      = wr_en && !push;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (prog_finished) state_nxt = ST_DRAIN;
            ST_DRAIN: if (empty || (pop && count_q == CW'(1))) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RUN;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

    out_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Gate the head so the bus reads zero whenever nothing is offered.
    assign out_data = out_valid ? head : '0;
    assign out_last = out_valid && (state == ST_DRAIN) && (count_q == CW'(1));
    assign count    = count_q;
    assign overflow = overflow_q;
    assign done     = (state == ST_DONE);

endmodule
